p2s_arbiter: RTL and testbench

Round-robin scheduler that shares one parallel-to-serial converter between N_REQ requesters. It arbitrates requests and latches the granted word into a shadow register. It then sequences the converter: a bit-select counter, a valid strobe and a done pulse, plus the serial bit itself. It sits between the requesting producers and the serial link driver, replacing the single-source start/OK controller on multi-source links.

---
 rtl/p2s_arbiter_if.sv | 29 ++
 rtl/p2s_arbiter.sv | 150 +++++++++++++++
 tb/tb_p2s_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/p2s_arbiter_if.sv
// Request/word side and serial side of the shared parallel-to-serial converter.
// master = requesters + link driver, slave = the arbiter.
interface p2s_arbiter_if #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 8,
    parameter int SEL_W  = 3,
    parameter int ID_W   = 2
);
    logic                      en;
    logic [N_REQ-1:0]          req;
    logic [N_REQ*DATA_W-1:0]   data_in;
    logic [N_REQ-1:0]          gnt;
    logic [ID_W-1:0]           src_id;
    logic [SEL_W-1:0]          sel;
    logic                      VO;
    logic                      SO;
    logic                      OK;
    logic                      busy;

    modport master (
        output en, req, data_in,
        input  gnt, src_id, sel, VO, SO, OK, busy
    );

    modport slave (
        input  en, req, data_in,
        output gnt, src_id, sel, VO, SO, OK, busy
    );
endinterface

// File: rtl/p2s_arbiter.sv
// Round-robin arbiter sharing one LSB-first serialiser between N_REQ requesters (P2S_PARITY_EN adds a parity bit).
// Latency: first serial bit valid the cycle after the grant edge; one word per DATA_W+1 (+1 with parity) cycles.
// Backpressure: none on the link; requesters hold req level until gnt, en=0 only blocks new grants.
module p2s_arbiter #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 8,
    parameter int SEL_W  = 3,
    parameter int ID_W   = 2
) (
    input  logic         ck,
    input  logic         reset,
    p2s_arbiter_if.slave bus
);

`ifdef P2S_PARITY_EN
    localparam bit PARITY_EN = 1'b1;
`else
    localparam bit PARITY_EN = 1'b0;
`endif

    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(DATA_W - 1);
    localparam logic [ID_W-1:0]  ID_LAST  = ID_W'(N_REQ - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    typedef struct packed {
        logic [N_REQ-1:0] gnt;
        logic [ID_W-1:0]  src_id;
        logic [SEL_W-1:0] sel;
        logic             vo;
        logic             so;
        logic             ok;
        logic             busy;
    } out_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] word_q, word_d;
    logic [ID_W-1:0]   ptr_q, ptr_d;
    logic              par_q, par_d;
    out_t              out_q, out_d;

    logic              found;
    logic [ID_W-1:0]   pick;
    logic              take;
    logic [DATA_W-1:0] cand;
    logic              last_data;
    logic              word_end;

    // Rotating scan starting at the pointer; first set request wins.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!found && bus.req[(int'(ptr_q) + k) % N_REQ]) begin
                found = 1'b1;
                pick  = ID_W'((int'(ptr_q) + k) % N_REQ);
            end
        end
    end

    assign take      = (state_q == IDLE) && bus.en && found;
    assign cand      = bus.data_in[int'(pick)*DATA_W +: DATA_W];
    assign last_data = (out_q.sel == SEL_LAST);
    // With parity the word ends after the extra parity cycle, otherwise on the last data bit.
    assign word_end  = PARITY_EN ? par_q : last_data;

    always_ff @(posedge ck or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            word_q  <= '0;
            ptr_q   <= '0;
            par_q   <= 1'b0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            ptr_q   <= ptr_d;
            par_q   <= par_d;
            out_q   <= out_d;
        end
    end

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        ptr_d   = ptr_q;
        par_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (take) begin
                    state_d = SHIFT;
                    word_d  = cand;
                    ptr_d   = (pick == ID_LAST) ? '0 : pick + ID_W'(1);
                end
            end
            SHIFT: begin
                if (word_end) begin
                    state_d = IDLE;
                end else begin
                    par_d = PARITY_EN && last_data;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        out_d        = '0;
        out_d.src_id = out_q.src_id;
        case (state_q)
            IDLE: begin
                if (take) begin
                    out_d.gnt    = N_REQ'(1) << pick;
                    out_d.src_id = pick;
                    out_d.vo     = 1'b1;
                    out_d.so     = cand[0];
                    out_d.busy   = 1'b1;
                end
            end
            SHIFT: begin
                if (!word_end) begin
                    out_d.vo   = 1'b1;
                    out_d.busy = 1'b1;
                    if (last_data) begin
                        out_d.sel = out_q.sel;
                        out_d.so  = ^word_q;
                        out_d.ok  = 1'b1;
                    end else begin
                        out_d.sel = out_q.sel + SEL_W'(1);
                        out_d.so  = word_q[out_q.sel + SEL_W'(1)];
                        out_d.ok  = !PARITY_EN && ((out_q.sel + SEL_W'(1)) == SEL_LAST);
                    end
                end
            end
            default: ;
        endcase
    end

    assign bus.gnt    = out_q.gnt;
    assign bus.src_id = out_q.src_id;
    assign bus.sel    = out_q.sel;
    assign bus.VO     = out_q.vo;
    assign bus.SO     = out_q.so;
    assign bus.OK     = out_q.ok;
    assign bus.busy   = out_q.busy;

endmodule

// File: tb/tb_p2s_arbiter.sv
// Directed bench for p2s_arbiter; output vector = {gnt, src_id, sel, VO, SO, OK, busy}.
module tb_p2s_arbiter;
    localparam int N_REQ  = 4;
    localparam int DATA_W = 8;
    localparam int SEL_W  = 3;
    localparam int ID_W   = 2;
`ifdef P2S_PARITY_EN
    localparam int NV = DATA_W + 1;
`else
    localparam int NV = DATA_W;
`endif

    logic ck    = 1'b0;
    logic reset = 1'b1;
    always #5 ck = ~ck;

    p2s_arbiter_if #(.N_REQ(N_REQ), .DATA_W(DATA_W), .SEL_W(SEL_W), .ID_W(ID_W)) bus ();

    p2s_arbiter #(.N_REQ(N_REQ), .DATA_W(DATA_W), .SEL_W(SEL_W), .ID_W(ID_W)) dut (
        .ck    (ck),
        .reset (reset),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    wire [12:0] obs = {bus.gnt, bus.src_id, bus.sel, bus.VO, bus.SO, bus.OK, bus.busy};

    localparam logic [12:0] ZERO = 13'd0;

    function automatic logic [12:0] idle_exp(input logic [1:0] s);
        return {4'b0000, s, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    endfunction

    // Expected outputs on serial cycle c of word w, granted with g to source s.
    function automatic logic [12:0] bit_exp(input logic [7:0] w, input int c,
                                            input logic [3:0] g, input logic [1:0] s);
        logic [2:0] sl;
        logic       so;
        logic [3:0] gg;
        if (c < DATA_W) begin
            sl = 3'(c);
            so = w[c];
        end else begin
            sl = 3'(DATA_W - 1);
            so = ^w;
        end
        gg = (c == 0) ? g : 4'b0000;
        return {gg, s, sl, 1'b1, so, (c == NV - 1), 1'b1};
    endfunction

    task automatic tick;
        @(posedge ck);
        #1;
    endtask

    task automatic do_reset;
        reset       = 1'b0;
        bus.en      = 1'b0;
        bus.req     = '0;
        bus.data_in = '0;
        repeat (2) tick;
        reset = 1'b1;
        tick;
    endtask

    task automatic test_reset;
        bus.en      = 1'b0;
        bus.req     = '0;
        bus.data_in = '0;
        #2 reset = 1'b0;
        #1;
        n_cmp++;
        if (obs !== ZERO) begin
            n_err++;
            $display("FAIL reset_state: got %h want %h", obs, ZERO);
        end
        bus.en      = 1'b1;
        bus.req     = 4'b1111;
        bus.data_in = 32'hFFFF_FFFF;
        tick;
        n_cmp++;
        if (obs !== ZERO) begin
            n_err++;
            $display("FAIL reset_hold: got %h want %h", obs, ZERO);
        end
        do_reset;
    endtask

    task automatic test_single;
        logic [12:0] e;
        bus.en      = 1'b1;
        bus.req     = 4'b0001;
        bus.data_in = 32'h0000_00A5;
        tick;
        bus.req     = '0;
        bus.data_in = 32'hFFFF_FFFF;
        for (int c = 0; c < NV; c++) begin
            if (c > 0) tick;
            e = bit_exp(8'hA5, c, 4'b0001, 2'd0);
            n_cmp++;
            if (obs !== e) begin
                n_err++;
                $display("FAIL single c=%0d: got %h want %h", c, obs, e);
            end
        end
        tick;
        n_cmp++;
        if (obs !== idle_exp(2'd0)) begin
            n_err++;
            $display("FAIL single_idle: got %h want %h", obs, idle_exp(2'd0));
        end
    endtask

    task automatic test_round_robin;
        logic [12:0] e;
        logic [7:0]  w;
        int          k;
        do_reset;
        bus.en      = 1'b1;
        bus.data_in = 32'h0804_0201;
        bus.req     = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            k = g % 4;
            w = 8'h01 << k;
            tick;
            if (g == 4) bus.req = '0;
            for (int c = 0; c < NV; c++) begin
                if (c > 0) tick;
                e = bit_exp(w, c, 4'b0001 << k, 2'(k));
                n_cmp++;
                if (obs !== e) begin
                    n_err++;
                    $display("FAIL rr g=%0d c=%0d: got %h want %h", g, c, obs, e);
                end
            end
            tick;
            n_cmp++;
            if (obs !== idle_exp(2'(k))) begin
                n_err++;
                $display("FAIL rr_idle g=%0d: got %h want %h", g, obs, idle_exp(2'(k)));
            end
        end
    endtask

    task automatic test_fairness;
        logic [12:0] e;
        do_reset;
        bus.en      = 1'b1;
        bus.data_in = 32'h0000_3C5A;
        bus.req     = 4'b0001;
        tick;
        bus.req = '0;
        e = bit_exp(8'h5A, 0, 4'b0001, 2'd0);
        n_cmp++;
        if (obs !== e) begin
            n_err++;
            $display("FAIL fair_first: got %h want %h", obs, e);
        end
        repeat (NV) tick;
        bus.req = 4'b0011;
        tick;
        e = bit_exp(8'h3C, 0, 4'b0010, 2'd1);
        n_cmp++;
        if (obs !== e) begin
            n_err++;
            $display("FAIL fair_req1: got %h want %h", obs, e);
        end
        repeat (NV) tick;
        n_cmp++;
        if (obs !== idle_exp(2'd1)) begin
            n_err++;
            $display("FAIL fair_idle: got %h want %h", obs, idle_exp(2'd1));
        end
        tick;
        bus.req = '0;
        e = bit_exp(8'h5A, 0, 4'b0001, 2'd0);
        n_cmp++;
        if (obs !== e) begin
            n_err++;
            $display("FAIL fair_req0: got %h want %h", obs, e);
        end
        repeat (NV) tick;
    endtask

    task automatic test_en_gating;
        logic [12:0] e;
        do_reset;
        bus.en      = 1'b1;
        bus.data_in = 32'h0000_96C3;
        bus.req     = 4'b0001;
        tick;
        bus.req = 4'b0010;
        for (int c = 0; c < NV; c++) begin
            if (c > 0) tick;
            e = bit_exp(8'hC3, c, 4'b0001, 2'd0);
            n_cmp++;
            if (obs !== e) begin
                n_err++;
                $display("FAIL en_word c=%0d: got %h want %h", c, obs, e);
            end
            if (c == 3) bus.en = 1'b0;
        end
        for (int i = 0; i < 5; i++) begin
            tick;
            n_cmp++;
            if (obs !== idle_exp(2'd0)) begin
                n_err++;
                $display("FAIL en_blocked i=%0d: got %h want %h", i, obs, idle_exp(2'd0));
            end
        end
        bus.en = 1'b1;
        tick;
        bus.req = '0;
        e = bit_exp(8'h96, 0, 4'b0010, 2'd1);
        n_cmp++;
        if (obs !== e) begin
            n_err++;
            $display("FAIL en_resume: got %h want %h", obs, e);
        end
        repeat (NV) tick;
    endtask

    task automatic test_reset_mid;
        logic [12:0] e;
        do_reset;
        bus.en      = 1'b1;
        bus.data_in = 32'h0081_00FF;
        bus.req     = 4'b0001;
        tick;
        bus.req = 4'b0100;
        repeat (5) tick;
        e = bit_exp(8'hFF, 5, 4'b0001, 2'd0);
        n_cmp++;
        if (obs !== e) begin
            n_err++;
            $display("FAIL mid_sel5: got %h want %h", obs, e);
        end
        #2 reset = 1'b0;
        #1;
        n_cmp++;
        if (obs !== ZERO) begin
            n_err++;
            $display("FAIL mid_async: got %h want %h", obs, ZERO);
        end
        tick;
        n_cmp++;
        if (obs !== ZERO) begin
            n_err++;
            $display("FAIL mid_held: got %h want %h", obs, ZERO);
        end
        @(negedge ck);
        reset = 1'b1;
        tick;
        bus.req = '0;
        e = bit_exp(8'h81, 0, 4'b0100, 2'd2);
        n_cmp++;
        if (obs !== e) begin
            n_err++;
            $display("FAIL mid_regrant: got %h want %h", obs, e);
        end
        repeat (NV) tick;
        n_cmp++;
        if (obs !== idle_exp(2'd2)) begin
            n_err++;
            $display("FAIL mid_idle: got %h want %h", obs, idle_exp(2'd2));
        end
    endtask

`ifdef P2S_PARITY_EN
    task automatic test_parity;
        logic [12:0] e;
        do_reset;
        bus.en      = 1'b1;
        bus.data_in = 32'h0000_0007;
        bus.req     = 4'b0001;
        tick;
        bus.req = '0;
        for (int c = 0; c < NV; c++) begin
            if (c > 0) tick;
            e = bit_exp(8'h07, c, 4'b0001, 2'd0);
            n_cmp++;
            if (obs !== e) begin
                n_err++;
                $display("FAIL parity c=%0d: got %h want %h", c, obs, e);
            end
        end
        n_cmp++;
        if (bus.SO !== 1'b1) begin
            n_err++;
            $display("FAIL parity_bit: got %b want 1", bus.SO);
        end
        tick;
    endtask
`endif

    initial begin
        bus.en      = 1'b0;
        bus.req     = '0;
        bus.data_in = '0;
        test_reset;
        test_single;
        test_round_robin;
        test_fairness;
        test_en_gating;
        test_reset_mid;
`ifdef P2S_PARITY_EN
        test_parity;
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
